// File: rtl/fold_karatsuba_mul_pkg.sv
// Shared widths and tap payload for the fold-stage constant multiplier.
package fold_karatsuba_mul_pkg;

    localparam int unsigned LIMB = 64;
    localparam int unsigned HALF = 128;
    localparam int unsigned FULL = 256;
    localparam int unsigned OUT  = 384;

    // Karatsuba widths: limb sum, middle term, sum product
    localparam int unsigned KW_S = 65;
    localparam int unsigned KW_M = 129;
    localparam int unsigned KW_C = 130;

    // Debug taps exposed by each 128x128 half multiplier
    typedef struct packed {
        logic [KW_C-1:0] c_1;   // stage-1 sum product X1X0*(k1+k0)
        logic [HALF-1:0] b_2;   // stage-2 forwarded low-limb product X0*k0
        logic [KW_M-1:0] m_2;   // stage-2 middle term X1*k0 + X0*k1
    } kara_taps_t;

endpackage

// File: rtl/fold_karatsuba_mul_karatsuba_128x128_const.sv
// Three-stage Karatsuba multiplier of a 128-bit operand by a 128-bit constant.
module karatsuba_128x128_const
    import fold_karatsuba_mul_pkg::*;
#(
    parameter logic [HALF-1:0] KJ = HALF'(1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [HALF-1:0]  x,
    input  logic [KW_S-1:0]  x1x0,
    output logic [FULL-1:0]  q,
    output kara_taps_t       taps
);

    localparam logic [LIMB-1:0] K_HI  = KJ[HALF-1:LIMB];
    localparam logic [LIMB-1:0] K_LO  = KJ[LIMB-1:0];
    localparam logic [KW_S-1:0] K_SUM = KW_S'(K_HI) + KW_S'(K_LO);

    logic [HALF-1:0] a1_d, a1_q, b1_d, b1_q;
    logic [KW_C-1:0] c1_d, c1_q;
    logic [HALF-1:0] a2_d, a2_q, b2_d, b2_q;
    logic [KW_M-1:0] m2_d, m2_q;
    logic [FULL-1:0] q3_d, q3_q;

    // Limb products, middle-term recovery and half-product assembly
    always_comb begin
        a1_d = HALF'(x[HALF-1:LIMB]) * HALF'(K_HI);
        b1_d = HALF'(x[LIMB-1:0]) * HALF'(K_LO);
        c1_d = KW_C'(x1x0) * KW_C'(K_SUM);
        a2_d = a1_q;
        b2_d = b1_q;
        // Exact for a consistent x1x0: the difference is X1*k0 + X0*k1 < 2^129
        m2_d = KW_M'(c1_q - KW_C'(a1_q) - KW_C'(b1_q));
        q3_d = (FULL'(a2_q) << HALF) + (FULL'(m2_q) << LIMB) + FULL'(b2_q);
    end

    // Pipeline registers, advancing every clock
    always_ff @(posedge clock) begin
        if (reset) begin
            a1_q <= '0;
            b1_q <= '0;
            c1_q <= '0;
            a2_q <= '0;
            b2_q <= '0;
            m2_q <= '0;
            q3_q <= '0;
        end else begin
            a1_q <= a1_d;
            b1_q <= b1_d;
            c1_q <= c1_d;
            a2_q <= a2_d;
            b2_q <= b2_d;
            m2_q <= m2_d;
            q3_q <= q3_d;
        end
    end

    assign q        = q3_q;
    assign taps.c_1 = c1_q;
    assign taps.b_2 = b2_q;
    assign taps.m_2 = m2_q;

endmodule

// File: rtl/fold_karatsuba_mul.sv
// Four-stage 128x256 constant multiplier for the modular fold stage.
module fold_karatsuba_mul
    import fold_karatsuba_mul_pkg::*;
#(
    parameter logic [FULL-1:0] K = {128'h1, 128'h1}
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [HALF-1:0]  X,
    input  logic [KW_S-1:0]  X1X0,
    output logic [OUT-1:0]   P,
    output logic             out_valid,
    output logic [KW_C-1:0]  sum_1,
    output logic [HALF-1:0]  P00_2,
    output logic [KW_M-1:0]  T1K_2,
    output logic [HALF-1:0]  result_4
);

    kara_taps_t      taps [2];
    logic [FULL-1:0] q    [2];

    // Half products X*K0 (j=0) and X*K1 (j=1)
    for (genvar j = 0; j < 2; j++) begin : g_half
        karatsuba_128x128_const #(
            .KJ(K[j*HALF +: HALF])
        ) u_kara (
            .clock (clock),
            .reset (reset),
            .x     (X),
            .x1x0  (X1X0),
            .q     (q[j]),
            .taps  (taps[j])
        );
    end

    logic [OUT-1:0] p_d, p_q;
    logic [3:0]     valid_d, valid_q;

    // Final combine of the two half products and valid delay line
    always_comb begin
        p_d     = OUT'(q[0]) + (OUT'(q[1]) << HALF);
        valid_d = {valid_q[2:0], in_valid};
    end

    // Output stage and valid pipe
    always_ff @(posedge clock) begin
        if (reset) begin
            p_q     <= '0;
            valid_q <= '0;
        end else begin
            p_q     <= p_d;
            valid_q <= valid_d;
        end
    end

    assign P         = p_q;
    assign out_valid = valid_q[3];
    assign result_4  = p_q[HALF-1:0];
    assign sum_1     = taps[0].c_1;
    assign P00_2     = taps[0].b_2;
    assign T1K_2     = taps[0].m_2;

endmodule

// File: tb/tb_fold_karatsuba_mul.sv
// Scoreboard bench for fold_karatsuba_mul across three fold constants.
module tb_fold_karatsuba_mul;
    import fold_karatsuba_mul_pkg::*;

    localparam logic [FULL-1:0] K_DEF = {128'h1, 128'h1};
    localparam logic [FULL-1:0] K_MAX = {FULL{1'b1}};
    localparam logic [FULL-1:0] K_RND =
        256'h9e3779b97f4a7c15f39cc0605cedc8341082276bf3a27251f86c6a11d0c18e95;
    localparam logic [HALF-1:0] X_A   = 128'h5b013b70ddf11560736ff50d7c982339;
    localparam logic [HALF-1:0] X_ONE = {HALF{1'b1}};

    logic            clock = 1'b0;
    logic            reset;
    logic            in_valid;
    logic [HALF-1:0] x;
    logic [KW_S-1:0] x1x0;

    logic [OUT-1:0]  p    [3];
    logic            ov   [3];
    logic [KW_C-1:0] s1   [3];
    logic [HALF-1:0] p00  [3];
    logic [KW_M-1:0] t1k  [3];
    logic [HALF-1:0] r4   [3];

    fold_karatsuba_mul #(.K(K_DEF)) u_def (
        .clock(clock), .reset(reset), .in_valid(in_valid), .X(x), .X1X0(x1x0),
        .P(p[0]), .out_valid(ov[0]), .sum_1(s1[0]), .P00_2(p00[0]), .T1K_2(t1k[0]),
        .result_4(r4[0]));

    fold_karatsuba_mul #(.K(K_MAX)) u_max (
        .clock(clock), .reset(reset), .in_valid(in_valid), .X(x), .X1X0(x1x0),
        .P(p[1]), .out_valid(ov[1]), .sum_1(s1[1]), .P00_2(p00[1]), .T1K_2(t1k[1]),
        .result_4(r4[1]));

    fold_karatsuba_mul #(.K(K_RND)) u_rnd (
        .clock(clock), .reset(reset), .in_valid(in_valid), .X(x), .X1X0(x1x0),
        .P(p[2]), .out_valid(ov[2]), .sum_1(s1[2]), .P00_2(p00[2]), .T1K_2(t1k[2]),
        .result_4(r4[2]));

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [HALF-1:0] x;
        int unsigned     due;
    } exp_t;

    exp_t sb [$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [FULL-1:0] k_of(input int i);
        case (i)
            0:       return K_DEF;
            1:       return K_MAX;
            default: return K_RND;
        endcase
    endfunction

    function automatic logic [OUT-1:0] ref_mul(input logic [HALF-1:0] a, input logic [FULL-1:0] k);
        return OUT'(a) * OUT'(k);
    endfunction

    task automatic chk(input string name, input logic [OUT-1:0] got, input logic [OUT-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic issue(input logic [HALF-1:0] v);
        exp_t e;
        @(posedge clock);
        #1;
        in_valid = 1'b1;
        x        = v;
        x1x0     = KW_S'(v[HALF-1:LIMB]) + KW_S'(v[LIMB-1:0]);
        e.x      = v;
        e.due    = cyc + 4;
        sb.push_back(e);
    endtask

    task automatic bubble();
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        x        = {$urandom(), $urandom(), $urandom(), $urandom()};
        x1x0     = KW_S'($urandom());
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_P[%0d]", tag, i), p[i], '0);
            chk($sformatf("%s_out_valid[%0d]", tag, i), OUT'(ov[i]), '0);
            chk($sformatf("%s_sum_1[%0d]", tag, i), OUT'(s1[i]), '0);
            chk($sformatf("%s_P00_2[%0d]", tag, i), OUT'(p00[i]), '0);
            chk($sformatf("%s_T1K_2[%0d]", tag, i), OUT'(t1k[i]), '0);
            chk($sformatf("%s_result_4[%0d]", tag, i), OUT'(r4[i]), '0);
        end
    endtask

    // Hand-computed taps for the default constant (K = 2^128 + 1)
    task automatic check_default_taps();
        @(posedge clock); #3;
        chk("def_sum_1", OUT'(s1[0]), OUT'(130'hce71307e5a893899));
        @(posedge clock); #3;
        chk("def_P00_2", OUT'(p00[0]), OUT'(128'h736ff50d7c982339));
        chk("def_T1K_2", OUT'(t1k[0]), OUT'(129'h5b013b70ddf11560));
        @(posedge clock);
        @(posedge clock); #3;
        chk("def_P_a", p[0], {128'h0, X_A, X_A});
        chk("def_result_4_a", OUT'(r4[0]), OUT'(X_A));
        chk("def_out_valid_a", OUT'(ov[0]), OUT'(1'b1));
        @(posedge clock); #3;
        chk("def_P_ones", p[0], {128'h0, X_ONE, X_ONE});
        chk("def_out_valid_ones", OUT'(ov[0]), OUT'(1'b1));
        chk("max_P_ones", p[1],
            384'hfffffffffffffffffffffffffffffffeffffffffffffffffffffffffffffffff00000000000000000000000000000001);
    endtask

    // Monitor: every output slot is compared against the scoreboard head
    always @(negedge clock) begin
        logic exp_v;
        exp_t e;
        exp_v = (sb.size() != 0) && (sb[0].due == cyc);
        for (int i = 0; i < 3; i++)
            chk($sformatf("out_valid[%0d]@%0d", i, cyc), OUT'(ov[i]), OUT'(exp_v));
        if (exp_v) begin
            e = sb.pop_front();
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("P[%0d]@%0d", i, cyc), p[i], ref_mul(e.x, k_of(i)));
                chk($sformatf("result_4[%0d]@%0d", i, cyc), OUT'(r4[i]),
                    OUT'(ref_mul(e.x, k_of(i)) & OUT'(X_ONE)));
            end
        end
    end

    initial begin
        logic [HALF-1:0] rv;
        reset    = 1'b1;
        in_valid = 1'b0;
        x        = '0;
        x1x0     = '0;
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Idle after reset: everything stays zero
        repeat (5) begin
            @(posedge clock);
            #1;
        end
        #2;
        check_zero("idle");

        // Test-plan vector then all-ones back-to-back
        issue(X_A);
        fork
            check_default_taps();
        join_none
        issue(X_ONE);
        repeat (6) bubble();

        // Corners, hand-checked for K = 2^256-1
        issue(128'h0);
        repeat (4) bubble();
        #2;
        chk("max_P_zero", p[1], '0);
        issue(128'h1);
        repeat (4) bubble();
        #2;
        chk("max_P_one", p[1], {128'h0, {FULL{1'b1}}});
        issue(X_ONE);
        issue(128'h8000000000000001_0000000000000001);
        issue(128'hffffffffffffffff_0000000000000000);
        repeat (6) bubble();

        // Random operands with random gaps
        repeat (1000) begin
            if ($urandom_range(0, 3) == 0) begin
                bubble();
            end else begin
                rv = {$urandom(), $urandom(), $urandom(), $urandom()};
                issue(rv);
            end
        end
        repeat (6) bubble();

        // Reset with three operands in flight
        issue(X_A);
        issue(X_ONE);
        issue(128'h0123456789abcdef_fedcba9876543210);
        @(posedge clock);
        #1;
        reset    = 1'b1;
        in_valid = 1'b0;
        x        = '0;
        x1x0     = '0;
        sb.delete();
        @(posedge clock);
        #3;
        check_zero("flush");
        #1;
        reset = 1'b0;
        repeat (6) bubble();

        // Recovery after flush
        issue(128'hdeadbeefcafef00d_0badc0de12345678);
        repeat (6) bubble();

        chk("sb_drained", OUT'(sb.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fold_karatsuba_mul.md
# fold_karatsuba_mul

Fully pipelined, fixed-constant 128×256-bit multiplier for the modular-multiplier folding stage. It computes P = X · K, where K is a 256-bit fold constant supplied as a parameter. Both 128×128 sub-products use Karatsuba with 64-bit limbs. It accepts one operand per clock and sits between the squaring/product datapath and the final modular reduction.

## Interface
- `K`, default `{128'h1, 128'h1}` (i.e. 2^128+1): 256-bit fold constant, K = K1·2^128 + K0, Kj = kj1·2^64 + kj0.
- `clock`  in  1  — single clock, rising edge.
- `reset`  in  1  — synchronous, active-high (one clock; reset is synchronous and active-high).
- `in_valid`  in  1  — operand valid.
- `X`  in  128  — operand, X = X1·2^64 + X0.
- `X1X0`  in  65  — caller-precomputed X[127:64] + X[63:0]. It is used unchecked; a mismatching value gives an undefined P.
- `P`  out  384  — registered product X·K.
- `out_valid`  out  1  — P valid.
- `sum_1`  out  130  — debug: stage-1 register X1X0·(k01+k00).
- `P00_2`  out  128  — debug: stage-2 register X0·k00.
- `T1K_2`  out  129  — debug: stage-2 Karatsuba middle term of X·K0, i.e. X1·k00 + X0·k01.
- `result_4`  out  128  — debug: P[127:0] (stage 4).

## Operation
- Constants: s0 = k01+k00 and s1 = k11+k10 (65 bits each) are elaboration-time localparams.
- Stage 1 registers the six limb products:
  - A0 = X1·k01, B0 = X0·k00 (128 bits each)
  - C0 = X1X0·s0 (130 bits)
  - A1 = X1·k11, B1 = X0·k10 (128 bits each)
  - C1 = X1X0·s1 (130 bits)
- Stage 2 registers:
  - Mj = Cj − Aj − Bj, 129 bits, exact and never negative.
  - Aj and Bj are forwarded unchanged.
- Stage 3 registers the 256-bit half products Qj = Aj·2^128 + Mj·2^64 + Bj. No truncation is allowed.
- Stage 4 registers P = Q0 + Q1·2^128. The result is 384 bits with no overflow possible.
- All arithmetic is unsigned, and every intermediate uses the full widths listed above.
- Data registers advance every clock regardless of `in_valid`. A separate 4-deep valid shift register carries `in_valid`.
- The debug outputs are direct register taps; `result_4` aliases P[127:0].

## Timing
- Latency is 4 clocks: operands sampled at edge n produce P and out_valid=1 after edge n+4.
- Throughput is 1 operand per clock, with no stall and no backpressure.
- Reset value of every output and pipeline register is 0, including `out_valid`, P, `sum_1`, `P00_2`, `T1K_2` and `result_4`.
- Reset mid-operation flushes all in-flight operands; no `out_valid` pulse appears for them.
- First valid after reset deassertion: operand at edge n appears at n+4.
- Back-to-back operands appear on consecutive cycles in order.
- A bubble (`in_valid`=0) gives `out_valid`=0 in the matching slot. P then holds whatever garbage the datapath computed, and consumers qualify it with `out_valid`.

## Structure
- Shared package holds:
  - widths: LIMB=64, HALF=128, FULL=256, OUT=384
  - Karatsuba width constants: 65, 129, 130
- The K/s0/s1 localparams stay local because they derive from the parameter.
- One sub-module is natural: `karatsuba_128x128_const`. It computes X·Kj (two instances, j=0/1) and exposes its stage-1/2 taps.
- The top level adds the stage-4 combine and the valid pipe.

## Test plan
- Reset held 1 cycle, then idle → all outputs 0 and `out_valid` 0 throughout.
- Default K, X=128'h5b013b70ddf11560736ff50d7c982339, X1X0=65'hce71307e5a893899, held one cycle:
  - `sum_1`=130'hce71307e5a893899 at +1
  - `P00_2`=128'h736ff50d7c982339 at +2
  - `T1K_2`=129'h5b013b70ddf11560 at +2
  - +4: `out_valid`=1, P={128'h0, X, X}, `result_4`=X
- Back-to-back: the cycle after the previous case, X=128'hffff…ffff, X1X0=65'h1fffffffffffffffe → at +4 (the next cycle), P={128'h0, 128'hff…ff, 128'hff…ff}; `out_valid` high for 2 consecutive cycles.
- Random K and X (X1X0 correct), 1000 operands with random `in_valid` gaps → P equals the 384-bit reference product; the `out_valid` pattern equals `in_valid` delayed by 4.
- Corners with K=2^256−1: X=0, X=1, and X=2^128−1. Expected P:
  - X=0 → 0
  - X=1 → 2^256−1
  - X=2^128−1 → (2^128−1)(2^256−1), which is the max width, no overflow
- Reset asserted while 3 operands are in flight → no `out_valid` for them; outputs 0 the cycle after the reset edge.
